// File: rtl/seq_detect_prog.sv
// seq_detect_prog: programmable serial pattern detector.
// A pattern of 1..PAT_MAX_LEN bits (MSB received first) is loaded at run time.
// Overlapping and non-overlapping matching are both supported.
// Each match gives a one-cycle registered pulse and bumps a saturating counter.
module seq_detect_prog #(
   parameter int PAT_MAX_LEN = 8,
   parameter int CNT_WIDTH   = 8,
   localparam int LEN_W      = $clog2(PAT_MAX_LEN + 1)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   cfg_load,
   input  logic [PAT_MAX_LEN-1:0] cfg_pattern,
   input  logic [LEN_W-1:0]       cfg_len,
   input  logic                   cfg_overlap,
   input  logic                   valid_in,
   input  logic                   data_in,
   input  logic                   clear_cnt,
   output logic                   sequence_detected,
   output logic [CNT_WIDTH-1:0]   match_count,
   output logic                   armed
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FILL = 2'd1,
      ST_HUNT = 2'd2
   } state_t;

   localparam logic [LEN_W:0]     MAX_LEN_C = (LEN_W + 1)'(PAT_MAX_LEN);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX_C = {CNT_WIDTH{1'b1}};

   // Bit mask with the low 'len' bits set; bits above the active length never
   // take part in the comparison.
   function automatic logic [PAT_MAX_LEN-1:0] len_mask(input logic [LEN_W-1:0] len);
      logic [PAT_MAX_LEN-1:0] m;
      m = {PAT_MAX_LEN{1'b0}};
      for (int i = 0; i < PAT_MAX_LEN; i++) begin
         if (i < int'(len)) begin
            m[i] = 1'b1;
         end else begin
            m[i] = 1'b0;
         end
      end
      return m;
   endfunction

   state_t                 state_q, state_d;
   logic [PAT_MAX_LEN-1:0] hist_q, hist_d;
   logic [LEN_W-1:0]       fill_cnt_q, fill_cnt_d;
   logic [PAT_MAX_LEN-1:0] pat_q, pat_d;
   logic [LEN_W-1:0]       len_q, len_d;
   logic                   ovl_q, ovl_d;
   logic                   det_q, det_d;
   logic                   armed_q, armed_d;
   logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;

   logic [PAT_MAX_LEN-1:0] win_s;
   logic [PAT_MAX_LEN-1:0] mask_s;
   logic [LEN_W:0]         fill_inc_s;
   logic                   accept_s;
   logic                   window_full_s;
   logic                   match_s;
   logic                   cfg_legal_s;

   // Datapath decode: accepted bit, candidate window and match condition.
   always_comb begin
      win_s         = {hist_q[PAT_MAX_LEN-2:0], data_in};
      mask_s        = len_mask(len_q);
      accept_s      = valid_in && !cfg_load && (state_q != ST_IDLE);
      // One extra bit so fill_cnt+1 cannot wrap when fill_cnt equals the length.
      fill_inc_s    = {1'b0, fill_cnt_q} + (LEN_W + 1)'(1'b1);
      window_full_s = (fill_inc_s >= {1'b0, len_q});
      match_s       = accept_s && window_full_s && ((win_s & mask_s) == (pat_q & mask_s));
      cfg_legal_s   = (cfg_len != {LEN_W{1'b0}}) && ({1'b0, cfg_len} <= MAX_LEN_C);
   end

   // FSM next-state, history/fill update, configuration capture and pulse.
   always_comb begin
      state_d    = state_q;
      hist_d     = hist_q;
      fill_cnt_d = fill_cnt_q;
      pat_d      = pat_q;
      len_d      = len_q;
      ovl_d      = ovl_q;
      det_d      = 1'b0;

      if (cfg_load) begin
         pat_d      = cfg_pattern;
         len_d      = cfg_len;
         ovl_d      = cfg_overlap;
         hist_d     = {PAT_MAX_LEN{1'b0}};
         fill_cnt_d = {LEN_W{1'b0}};
         if (cfg_legal_s) begin
            state_d = ST_FILL;
         end else begin
            state_d = ST_IDLE;
         end
      end else if (accept_s) begin
         hist_d = win_s;
         // fill_cnt saturates at the active length once the window is full.
         if (window_full_s) begin
            fill_cnt_d = len_q;
         end else begin
            fill_cnt_d = fill_inc_s[LEN_W-1:0];
         end
         if (match_s) begin
            det_d = 1'b1;
            if (ovl_q) begin
               state_d = ST_HUNT;
            end else begin
               // Restart collection so the matched bits cannot be reused.
               fill_cnt_d = {LEN_W{1'b0}};
               state_d    = ST_FILL;
            end
         end else begin
            case (state_q)
               ST_FILL: begin
                  if (window_full_s) begin
                     state_d = ST_HUNT;
                  end else begin
                     state_d = ST_FILL;
                  end
               end
               ST_HUNT: state_d = ST_HUNT;
               default: state_d = ST_IDLE;
            endcase
         end
      end else begin
         // No accepted bit: everything holds and no pulse is produced.
         state_d = state_q;
      end

      armed_d = (state_d != ST_IDLE);
   end

   // Saturating match counter; a clear coinciding with a match leaves one count.
   always_comb begin
      cnt_d = cnt_q;
      if (clear_cnt) begin
         if (match_s) begin
            cnt_d = CNT_WIDTH'(1'b1);
         end else begin
            cnt_d = {CNT_WIDTH{1'b0}};
         end
      end else if (match_s) begin
         if (cnt_q != CNT_MAX_C) begin
            cnt_d = cnt_q + CNT_WIDTH'(1'b1);
         end else begin
            cnt_d = cnt_q;
         end
      end else begin
         cnt_d = cnt_q;
      end
   end

   // State and output registers with synchronous reset taking priority.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         hist_q     <= {PAT_MAX_LEN{1'b0}};
         fill_cnt_q <= {LEN_W{1'b0}};
         pat_q      <= {PAT_MAX_LEN{1'b0}};
         len_q      <= {LEN_W{1'b0}};
         ovl_q      <= 1'b0;
         det_q      <= 1'b0;
         armed_q    <= 1'b0;
         cnt_q      <= {CNT_WIDTH{1'b0}};
      end else begin
         state_q    <= state_d;
         hist_q     <= hist_d;
         fill_cnt_q <= fill_cnt_d;
         pat_q      <= pat_d;
         len_q      <= len_d;
         ovl_q      <= ovl_d;
         det_q      <= det_d;
         armed_q    <= armed_d;
         cnt_q      <= cnt_d;
      end
   end

   assign sequence_detected = det_q;
   assign match_count       = cnt_q;
   assign armed             = armed_q;

endmodule
